// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: converter FSM states
// and active-low seven-segment encodings (bit 0 = segment a ... bit 6 = g).
package calc_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Special glyphs, active low
  localparam logic [6:0] SEG_BLANK = 7'h7F;  // all segments off
  localparam logic [6:0] SEG_MINUS = 7'h3F;  // g only
  localparam logic [6:0] SEG_E     = 7'h06;  // a, d, e, f, g

  // Digit glyphs 0-9, active low; element [n] is the glyph for digit n
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg7_digit.sv
// One display digit: maps a BCD digit plus blank/minus/error controls to an
// active-low seven-segment pattern. Priority is error, minus, blank, digit.
module seg7_digit
  import calc_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_minus,
  input  logic       i_err,
  output logic [6:0] o_seg
);

  // Select the glyph; non-BCD codes fall back to blank
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_err) begin
      o_seg = SEG_E;
    end else if (i_minus) begin
      o_seg = SEG_MINUS;
    end else if (i_blank) begin
      o_seg = SEG_BLANK;
    end else if (i_digit <= 4'd9) begin
      o_seg = SEG_DIGIT[i_digit];
    end
  end

endmodule

// File: rtl/bin_to_seg_display.sv
// Sequential binary-to-seven-segment display engine. A WIDTH-bit unsigned or
// two's-complement value is converted to DIGITS packed BCD digits with
// shift-and-add-3 (one bit per clock), then rendered as active-low segments
// with minus sign and overflow ("E") indication.
// Optional feature macro: LEADING_ZERO_BLANK_EN -- blanks leading zeros and
// floats the minus sign next to the most significant nonzero digit.
module bin_to_seg_display
  import calc_pkg::*;
#(
  parameter int WIDTH  = 40,
  parameter int DIGITS = 6
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic                  signed_in,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS*7-1:0]   HEX
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = DIGITS * 4;

  // Display shown out of reset: "0" in digit 0, other digits per build option
  function automatic logic [DIGITS*7-1:0] f_hex_reset();
    logic [DIGITS*7-1:0] h;
    h = '0;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      h[i*7 +: 7] = (i == 0) ? SEG_DIGIT[0] : SEG_BLANK;
`else
      h[i*7 +: 7] = SEG_DIGIT[0];
`endif
    end
    return h;
  endfunction

  localparam logic [DIGITS*7-1:0] HEX_RESET = f_hex_reset();

  state_t              r_state;
  logic [WIDTH-1:0]    r_value;
  logic                r_signed;
  logic                r_neg;
  logic [WIDTH-1:0]    r_mag;
  logic [BW-1:0]       r_work;
  logic                r_ovf;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic [BW-1:0]       r_bcd;
  logic [DIGITS*7-1:0] r_hex;

  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_work_next;
  logic [WIDTH-1:0]    w_mag_next;
  logic                w_ovf_next;
  logic                w_ovf_final;
  logic [DIGITS-1:0]   w_lead;
  logic [DIGITS-1:0]   w_minus;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_err;
  logic [DIGITS*7-1:0] w_hex;

  // Add-3 correction on every digit that would exceed 9 after doubling
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_work[gi*4 +: 4] >= 4'd5) ?
                                (r_work[gi*4 +: 4] + 4'd3) : r_work[gi*4 +: 4];
    end
  endgenerate

  // One shift step of {bcd, mag}; a 1 leaving the top digit is a lost carry
  assign w_work_next = {w_adj[BW-2:0], r_mag[WIDTH-1]};
  assign w_mag_next  = {r_mag[WIDTH-2:0], 1'b0};
  assign w_ovf_next  = r_ovf | w_adj[BW-1];

  // A negative result needs the top digit free for the sign
  assign w_ovf_final = w_ovf_next | (r_neg & (w_work_next[BW-1 -: 4] != 4'd0));

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_nz;
  logic [DIGITS-1:0] w_nz_above;

  // A digit is a leading zero when it and everything above it is zero;
  // the sign goes in the lowest leading-zero position
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lead
      assign w_nz[gi] = |w_work_next[gi*4 +: 4];
      if (gi == DIGITS - 1) begin : g_top
        assign w_nz_above[gi] = 1'b0;
      end else begin : g_below
        assign w_nz_above[gi] = |w_work_next[BW-1:(gi+1)*4];
      end
      if (gi == 0) begin : g_lsd
        assign w_lead[gi]  = 1'b0;
        assign w_minus[gi] = 1'b0;
      end else begin : g_upper
        assign w_lead[gi]  = ~w_nz[gi] & ~w_nz_above[gi];
        assign w_minus[gi] = r_neg & w_lead[gi] & ~w_lead[gi-1];
      end
    end
  endgenerate
`else
  // Every digit is shown; the sign always sits in the top digit
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lead
      assign w_lead[gi]  = 1'b0;
      assign w_minus[gi] = r_neg && (gi == DIGITS - 1);
    end
  endgenerate
`endif

  // Overflow overrides everything: E in the top digit, blanks below
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_err[gi]   = w_ovf_final && (gi == DIGITS - 1);
      assign w_blank[gi] = w_ovf_final | w_lead[gi];

      seg7_digit u_seg7_digit (
        .i_digit (w_work_next[gi*4 +: 4]),
        .i_blank (w_blank[gi]),
        .i_minus (w_minus[gi] & ~w_ovf_final),
        .i_err   (w_err[gi]),
        .o_seg   (w_hex[gi*7 +: 7])
      );
    end
  endgenerate

  // Conversion sequencer; results are captured on the edge into DONE so they
  // are already visible while done is high
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_value    <= '0;
      r_signed   <= 1'b0;
      r_neg      <= 1'b0;
      r_mag      <= '0;
      r_work     <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
      r_hex      <= HEX_RESET;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_value  <= value;
            r_signed <= signed_in;
            r_busy   <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_neg   <= r_signed & r_value[WIDTH-1];
          r_mag   <= (r_signed & r_value[WIDTH-1]) ? (~r_value + WIDTH'(1)) : r_value;
          r_work  <= '0;
          r_ovf   <= 1'b0;
          r_cnt   <= CW'(WIDTH);
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_work <= w_work_next;
          r_mag  <= w_mag_next;
          r_ovf  <= w_ovf_next;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state    <= DONE;
            r_bcd      <= w_work_next;
            r_overflow <= w_ovf_final;
            r_hex      <= w_hex;
            r_done     <= 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign bcd      = r_bcd;
  assign HEX      = r_hex;

endmodule
